// File: rtl/tts_pkg.sv
// rtl/tts_pkg.sv - shared types and default sizing for the transient timer scheduler
package tts_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TIME,
        COMMIT
    } tts_state_t;

    localparam int DEF_CHANNELS = 8;
    localparam int DEF_TICK_DIV = 10000;
    localparam int DEF_DELAY_W  = 4;

    // Counter must hold the largest delay_sel * TICK_DIV product without truncation
    localparam int CNT_W = $clog2((2**DEF_DELAY_W - 1) * DEF_TICK_DIV + 1);
    localparam int IDX_W = $clog2(DEF_CHANNELS);

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker: lowest request at or above ptr, wrapping
module rr_arbiter #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    int               slot;
    logic [IDX_W-1:0] slot_idx;

    // Scan from the farthest slot back toward ptr so the nearest request wins
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        slot        = 0;
        slot_idx    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            slot = int'(ptr) + i;
            if (slot >= N) begin
                slot = slot - N;
            end
            slot_idx = IDX_W'(slot);
            if (req[slot_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = slot_idx;
            end
        end
    end

endmodule

// File: rtl/transient_timer_scheduler.sv
// rtl/transient_timer_scheduler.sv - one settle timer shared round-robin among monitored lines
module transient_timer_scheduler
    import tts_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int DELAY_W  = DEF_DELAY_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [CHANNELS-1:0]         chan_in,
    input  logic [DELAY_W-1:0]          delay_sel,
    output logic [CHANNELS-1:0]         stable_out,
    output logic [CHANNELS-1:0]         change_pulse,
    output logic                        busy,
    output logic [$clog2(CHANNELS)-1:0] active_chan
);

    localparam int IDX_W = $clog2(CHANNELS);
    localparam int CNT_W = $clog2((2**DELAY_W - 1) * TICK_DIV + 1);

    tts_state_t       state;
    logic [CHANNELS-1:0] in_q;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] next_chan;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;

    rr_arbiter #(
        .N     (CHANNELS),
        .IDX_W (IDX_W)
    ) u_arb (
        .req         (in_q ^ stable_out),
        .ptr         (rr_ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign next_chan = (active_chan == IDX_W'(CHANNELS - 1)) ? '0 : active_chan + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            in_q         <= '0;
            cnt          <= '0;
            rr_ptr       <= '0;
            stable_out   <= '0;
            change_pulse <= '0;
            busy         <= 1'b0;
            active_chan  <= '0;
        end else begin
            in_q         <= chan_in;
            change_pulse <= '0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        active_chan <= grant_idx;
                        cnt         <= CNT_W'(delay_sel) * CNT_W'(TICK_DIV);
                        busy        <= 1'b1;
                        state       <= TIME;
                    end
                end
                TIME: begin
                    // A reversion wins over expiry so a glitch ending on the last count never commits
                    if (in_q[active_chan] == stable_out[active_chan]) begin
                        rr_ptr <= next_chan;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else if (cnt == '0) begin
                        state <= COMMIT;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                COMMIT: begin
                    stable_out[active_chan]   <= in_q[active_chan];
                    change_pulse[active_chan] <= 1'b1;
                    rr_ptr                    <= next_chan;
                    busy                      <= 1'b0;
                    state                     <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_transient_timer_scheduler.sv
// tb/tb_transient_timer_scheduler.sv - directed self-checking bench for transient_timer_scheduler
module tb_transient_timer_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] chan_in;
    logic [3:0] delay_sel;
    logic [7:0] stable_out;
    logic [7:0] change_pulse;
    logic       busy;
    logic [2:0] active_chan;

    int         n_cmp  = 0;
    int         n_fail = 0;
    int         pulse_edge_q[$];
    logic [7:0] pulse_val_q[$];
    int         busy_cycles;
    int         multi_hot;
    logic       seen_busy;
    logic [2:0] first_busy_chan;

    transient_timer_scheduler #(
        .CHANNELS (8),
        .TICK_DIV (4),
        .DELAY_W  (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .chan_in      (chan_in),
        .delay_sel    (delay_sel),
        .stable_out   (stable_out),
        .change_pulse (change_pulse),
        .busy         (busy),
        .active_chan  (active_chan)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Records pulses as (edge index, value); edge 1 is the first edge after the call
    task automatic watch(input int edges);
        pulse_edge_q.delete();
        pulse_val_q.delete();
        busy_cycles     = 0;
        multi_hot       = 0;
        seen_busy       = 1'b0;
        first_busy_chan = '0;
        for (int k = 1; k <= edges; k++) begin
            step();
            if (busy === 1'b1) begin
                busy_cycles++;
                if (!seen_busy) begin
                    seen_busy       = 1'b1;
                    first_busy_chan = active_chan;
                end
            end
            if (change_pulse !== 8'h00) begin
                pulse_edge_q.push_back(k);
                pulse_val_q.push_back(change_pulse);
                if ($countones(change_pulse) != 1) multi_hot++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; chan_in = 8'h00; delay_sel = 4'd0;
        step(); step();
        n_cmp++; if (stable_out !== 8'h00) begin n_fail++; $display("FAIL reset_stable: got %h want 00", stable_out); end
        n_cmp++; if (change_pulse !== 8'h00) begin n_fail++; $display("FAIL reset_pulse: got %h want 00", change_pulse); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (active_chan !== 3'd0) begin n_fail++; $display("FAIL reset_active: got %0d want 0", active_chan); end
        reset = 1'b0;
    endtask

    task automatic test_basic_delay();
        delay_sel = 4'd2; chan_in = 8'h01;
        step();
        watch(14);
        n_cmp++; if (pulse_edge_q.size() != 1) begin n_fail++; $display("FAIL basic_pulse_count: got %0d want 1", pulse_edge_q.size()); end
        else begin
            n_cmp++; if (pulse_edge_q[0] != 11) begin n_fail++; $display("FAIL basic_pulse_edge: got %0d want 11", pulse_edge_q[0]); end
            n_cmp++; if (pulse_val_q[0] !== 8'h01) begin n_fail++; $display("FAIL basic_pulse_val: got %h want 01", pulse_val_q[0]); end
        end
        n_cmp++; if (busy_cycles != 10) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 10", busy_cycles); end
        n_cmp++; if (stable_out !== 8'h01) begin n_fail++; $display("FAIL basic_stable: got %h want 01", stable_out); end
    endtask

    task automatic test_zero_delay();
        delay_sel = 4'd0; chan_in = 8'h09;
        step();
        watch(6);
        n_cmp++; if (first_busy_chan !== 3'd3) begin n_fail++; $display("FAIL zero_active_chan: got %0d want 3", first_busy_chan); end
        n_cmp++; if (pulse_edge_q.size() != 1) begin n_fail++; $display("FAIL zero_pulse_count: got %0d want 1", pulse_edge_q.size()); end
        else begin
            n_cmp++; if (pulse_edge_q[0] != 3) begin n_fail++; $display("FAIL zero_pulse_edge: got %0d want 3", pulse_edge_q[0]); end
            n_cmp++; if (pulse_val_q[0] !== 8'h08) begin n_fail++; $display("FAIL zero_pulse_val: got %h want 08", pulse_val_q[0]); end
        end
        n_cmp++; if (busy_cycles != 2) begin n_fail++; $display("FAIL zero_busy_cycles: got %0d want 2", busy_cycles); end
        n_cmp++; if (stable_out !== 8'h09) begin n_fail++; $display("FAIL zero_stable: got %h want 09", stable_out); end
    endtask

    task automatic test_glitch();
        delay_sel = 4'd3; chan_in = 8'h29;
        step(); step(); step();
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_timing: got %b want 1", busy); end
        n_cmp++; if (active_chan !== 3'd5) begin n_fail++; $display("FAIL glitch_active: got %0d want 5", active_chan); end
        chan_in = 8'h09;
        watch(20);
        n_cmp++; if (pulse_edge_q.size() != 0) begin n_fail++; $display("FAIL glitch_pulse_count: got %0d want 0", pulse_edge_q.size()); end
        n_cmp++; if (busy_cycles != 1) begin n_fail++; $display("FAIL glitch_abort_latency: got %0d want 1", busy_cycles); end
        n_cmp++; if (stable_out !== 8'h09) begin n_fail++; $display("FAIL glitch_stable: got %h want 09", stable_out); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle: got %b want 0", busy); end
    endtask

    task automatic test_all_lines();
        reset = 1'b1; chan_in = 8'h00;
        step(); step();
        reset = 1'b0; delay_sel = 4'd1; chan_in = 8'hFF;
        step();
        watch(60);
        n_cmp++; if (pulse_edge_q.size() != 8) begin n_fail++; $display("FAIL all_pulse_count: got %0d want 8", pulse_edge_q.size()); end
        else begin
            for (int i = 0; i < 8; i++) begin
                n_cmp++; if (pulse_edge_q[i] != 7 * (i + 1)) begin n_fail++; $display("FAIL all_edge_%0d: got %0d want %0d", i, pulse_edge_q[i], 7 * (i + 1)); end
                n_cmp++; if (pulse_val_q[i] !== 8'(1 << i)) begin n_fail++; $display("FAIL all_val_%0d: got %h want %h", i, pulse_val_q[i], 8'(1 << i)); end
            end
        end
        n_cmp++; if (multi_hot != 0) begin n_fail++; $display("FAIL all_one_hot: got %0d multi-hot pulses want 0", multi_hot); end
        n_cmp++; if (stable_out !== 8'hFF) begin n_fail++; $display("FAIL all_stable: got %h want ff", stable_out); end
    endtask

    task automatic test_fairness();
        delay_sel = 4'd0; chan_in = 8'hDF;
        step();
        watch(5);
        n_cmp++; if (pulse_val_q.size() != 1 || pulse_val_q[0] !== 8'h20) begin n_fail++; $display("FAIL fair_commit5: got %0d pulses want one pulse of 20", pulse_val_q.size()); end
        chan_in = 8'h5B;
        step();
        watch(10);
        n_cmp++; if (pulse_edge_q.size() != 2) begin n_fail++; $display("FAIL fair_pulse_count: got %0d want 2", pulse_edge_q.size()); end
        else begin
            n_cmp++; if (pulse_val_q[0] !== 8'h80) begin n_fail++; $display("FAIL fair_first: got %h want 80", pulse_val_q[0]); end
            n_cmp++; if (pulse_edge_q[0] != 3) begin n_fail++; $display("FAIL fair_first_edge: got %0d want 3", pulse_edge_q[0]); end
            n_cmp++; if (pulse_val_q[1] !== 8'h04) begin n_fail++; $display("FAIL fair_second: got %h want 04", pulse_val_q[1]); end
            n_cmp++; if (pulse_edge_q[1] != 6) begin n_fail++; $display("FAIL fair_second_edge: got %0d want 6", pulse_edge_q[1]); end
        end
        n_cmp++; if (stable_out !== 8'h5B) begin n_fail++; $display("FAIL fair_stable: got %h want 5b", stable_out); end
    endtask

    task automatic test_reset_mid_time();
        reset = 1'b1; chan_in = 8'h00;
        step();
        reset = 1'b0; delay_sel = 4'd2; chan_in = 8'h10;
        step(); step(); step(); step();
        n_cmp++; if (busy !== 1'b1 || active_chan !== 3'd4) begin n_fail++; $display("FAIL rst_mid_timing: got busy %b chan %0d want busy 1 chan 4", busy, active_chan); end
        reset = 1'b1;
        step();
        n_cmp++; if (stable_out !== 8'h00) begin n_fail++; $display("FAIL rst_mid_stable: got %h want 00", stable_out); end
        n_cmp++; if (change_pulse !== 8'h00) begin n_fail++; $display("FAIL rst_mid_pulse: got %h want 00", change_pulse); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        n_cmp++; if (active_chan !== 3'd0) begin n_fail++; $display("FAIL rst_mid_active: got %0d want 0", active_chan); end
        step();
        reset = 1'b0;
        step();
        watch(14);
        n_cmp++; if (pulse_edge_q.size() != 1) begin n_fail++; $display("FAIL rst_retime_count: got %0d want 1", pulse_edge_q.size()); end
        else begin
            n_cmp++; if (pulse_edge_q[0] != 11) begin n_fail++; $display("FAIL rst_retime_edge: got %0d want 11", pulse_edge_q[0]); end
            n_cmp++; if (pulse_val_q[0] !== 8'h10) begin n_fail++; $display("FAIL rst_retime_val: got %h want 10", pulse_val_q[0]); end
        end
        n_cmp++; if (stable_out !== 8'h10) begin n_fail++; $display("FAIL rst_retime_stable: got %h want 10", stable_out); end
    endtask

    initial begin
        reset = 1'b1; chan_in = 8'h00; delay_sel = 4'd0;
        test_reset();
        test_basic_delay();
        test_zero_delay();
        test_glitch();
        test_all_lines();
        test_fairness();
        test_reset_mid_time();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/transient_timer_scheduler.md
# transient_timer_scheduler

Shares one settle-delay timer among eight monitored input lines. Each line that departs from its last qualified value requests a settle period; a round-robin scheduler grants the timer to one line at a time. A line whose value holds for the full period is committed to `stable_out` with a one-cycle change pulse. The block sits between the raw `ui_in` pins and the state-monitor logic, replacing per-line counters with one shared counter.

## Interface
- `CHANNELS`, 8: number of monitored lines (power of two, at most 8).
- `TICK_DIV`, 10000: clock cycles per delay unit (1 s at the 10 kHz board clock).
- `DELAY_W`, 4: width of the delay select.
- `clk`  in  1  the single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `chan_in`  in  CHANNELS  raw monitored lines, asynchronous to nothing (already in `clk` domain).
- `delay_sel`  in  DELAY_W  settle time in units of `TICK_DIV` cycles; 0 means minimum latency.
- `stable_out`  out  CHANNELS  last qualified value per line.
- `change_pulse`  out  CHANNELS  one-cycle pulse on the line just committed.
- `busy`  out  1  high while the timer is granted (TIME or COMMIT).
- `active_chan`  out  $clog2(CHANNELS)  index of the line that holds the timer.

## Operation
- `in_q` registers `chan_in` every cycle.
- A line is pending when `in_q[i] != stable_out[i]`. Pending is combinational and has no stored flag.
- Round-robin pick: the lowest pending index at or above `rr_ptr`, wrapping to 0.
- States:
  - IDLE: if any line is pending, latch the picked index into `active_chan`, load `cnt = delay_sel * TICK_DIV` and go to TIME. Otherwise stay in IDLE.
  - TIME:
    - If `in_q[active_chan] == stable_out[active_chan]`, the line reverted (glitch). Abort to IDLE with no pulse and set `rr_ptr = active_chan+1`.
    - Else if `cnt == 0`, go to COMMIT.
    - Else `cnt <= cnt - 1`.
  - COMMIT:
    - Set `stable_out[active_chan] <= in_q[active_chan]` and assert `change_pulse[active_chan]` for this one edge.
    - Set `rr_ptr <= active_chan+1`, wrapping modulo CHANNELS.
    - Return to IDLE.
- `delay_sel` is sampled only on the IDLE→TIME transition. Changes during TIME are ignored.
- `cnt` width is `$clog2((2**DELAY_W-1)*TICK_DIV+1)`, which is 18 bits at the defaults. The product must not truncate.
- Lines that change while another line holds the timer wait their turn. A line that toggles and reverts before it is granted is never serviced and produces no pulse.
- At most one `change_pulse` bit is high in any cycle.

## Timing
- Reset values: `stable_out=0`, `change_pulse=0`, `busy=0`, `active_chan=0`, `in_q=0`, `rr_ptr=0`, `cnt=0`, state IDLE.
- Reset asserted mid-TIME or mid-COMMIT aborts immediately. No pulse is emitted and `stable_out` clears.
- Let `chan_in` change be captured at edge E0 and N = `delay_sel*TICK_DIV`:
  - IDLE→TIME at E1.
  - TIME→COMMIT at E(N+2).
  - `stable_out` and `change_pulse` update at E(N+3).
  - With `delay_sel=0`: 3 edges.
- Back-to-back service: the next pending line enters TIME 2 edges after the previous commit (COMMIT→IDLE, then IDLE→TIME).
- Abort check has priority over expiry. A reversion seen in the same cycle as `cnt==0` aborts.

## Structure
- Package `tts_pkg`:
  - state enum {IDLE, TIME, COMMIT}
  - default `CHANNELS`, `TICK_DIV`, `DELAY_W`
  - derived `CNT_W` and `IDX_W`
- Sub-module `rr_arbiter`: combinational round-robin picker. Inputs are the request vector and pointer; outputs are `grant_valid` and `grant_idx`. It is reusable for other shared resources on the chip.
- Top-level holds `in_q`, FSM, counter, `rr_ptr` and output registers.

## Test plan
- Reset, then `chan_in=8'h01` and `delay_sel=2` with `TICK_DIV=4`: `stable_out=8'h01` and `change_pulse=8'h01` for one cycle exactly 11 edges after capture. `busy` is high for 10 cycles.
- `delay_sel=0`, toggle bit 3 high: commit 3 edges after capture. `active_chan=3`.
- Glitch: bit 5 goes high, then returns low after 3 cycles, with `delay_sel=3` and `TICK_DIV=4`: abort, no pulse, `stable_out` unchanged, back to IDLE.
- `chan_in` goes 0→8'hFF in one cycle, `delay_sel=1`:
  - commits occur in order 0,1,…,7, each 7 edges apart;
  - `change_pulse` is one-hot each time;
  - final `stable_out=8'hFF`.
- Fairness: `rr_ptr=6` after committing 5; bits 2 and 7 pending together: 7 is granted first, then 2.
- Assert `reset` mid-TIME on bit 4: all outputs return to reset values next edge with no pulse. After release, bit 4 still high is re-timed from scratch.
